// File: rtl/fetch_pkg.sv
// Shared FSM state type, word geometry and byte-lane helper
// for the bytecode fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  localparam int WORD_BYTES = 4;
  localparam int OFF_W = $clog2(WORD_BYTES);

  // Big-endian lane select: offset 0 is the most significant byte.
  function automatic logic [7:0] word_byte(
    input logic [31:0]      w,
    input logic [OFF_W-1:0] off
  );
    logic [31:0] s;
    s = w << {off, 3'b000};
    return s[31:24];
  endfunction

endpackage

// File: rtl/fetch_word_fifo.sv
// Prefetch word buffer: flush has priority, push and pop
// may happen together even when full.
module fetch_word_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   pc_reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge pc_reset) begin
    if (!pc_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/bytecode_fetch_ctrl.sv
// Bytecode prefetcher: word reads into a small buffer, bytes out.
// Define BYTECODE_FETCH_STATS_EN to add fetch/stall counters.
module bytecode_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUF_WORDS     = 2
) (
  input  logic                     clk,
  input  logic                     pc_reset,
  input  logic [ADDRESS_WIDTH-1:0] pc_reset_value,
  output logic                     mem_start,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  input  logic                     mem_ready,
  input  logic [31:0]              mem_data,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic [7:0]               byte_out,
  output logic [ADDRESS_WIDTH-1:0] byte_pc,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_addr
`ifdef BYTECODE_FETCH_STATS_EN
  ,
  output logic [15:0]              fetch_count,
  output logic [15:0]              stall_count
`endif
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int CW = $clog2(BUF_WORDS) + 1;

  fetch_state_e     state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [AW-1:0]    tgt_q, tgt_d;
  logic [AW-1:0]    pc_q;
  logic [OFF_W-1:0] off_q;
  logic             push, pop, take;
  logic             full, empty;
  logic [CW-1:0]    count;
  logic [31:0]      head;

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return {a[AW-1:OFF_W], OFF_W'(0)};
  endfunction

  assign mem_start   = (state_q != IDLE);
  assign mem_address = addr_q;
  assign byte_valid  = ~empty;
  assign byte_pc     = pc_q;
  assign byte_out    = byte_valid ? word_byte(head, off_q) : 8'h00;
  assign take        = byte_valid & byte_ready & ~redirect;
  assign pop         = take & (off_q == OFF_W'(WORD_BYTES - 1));
  assign push        = (state_q == REQ) & mem_ready & ~redirect;

  fetch_word_fifo #(
    .DEPTH (BUF_WORDS),
    .WIDTH (32)
  ) u_fifo (
    .clk      (clk),
    .pc_reset (pc_reset),
    .flush    (redirect),
    .push     (push),
    .wdata    (mem_data),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      IDLE: begin
        if (!full) state_d = REQ;
      end
      REQ: begin
        if (mem_ready) begin
          addr_d = addr_q + AW'(WORD_BYTES);
          if (count == CW'(BUF_WORDS - 1) && !pop) state_d = IDLE;
        end
      end
      FLUSH: begin
        if (mem_ready) begin
          addr_d  = tgt_q;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    // An open read must finish before the jump target is requested.
    if (redirect) begin
      tgt_d = align(redirect_addr);
      if (state_q != IDLE && !mem_ready) begin
        addr_d  = addr_q;
        state_d = FLUSH;
      end else begin
        addr_d  = align(redirect_addr);
        state_d = REQ;
      end
    end
  end

  always_ff @(posedge clk or negedge pc_reset) begin
    if (!pc_reset) begin
      state_q <= IDLE;
      addr_q  <= align(pc_reset_value);
      tgt_q   <= align(pc_reset_value);
      pc_q    <= pc_reset_value;
      off_q   <= pc_reset_value[OFF_W-1:0];
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tgt_q   <= tgt_d;
      if (redirect) begin
        pc_q  <= redirect_addr;
        off_q <= redirect_addr[OFF_W-1:0];
      end else if (take) begin
        pc_q  <= pc_q + AW'(1);
        off_q <= off_q + OFF_W'(1);
      end
    end
  end

`ifdef BYTECODE_FETCH_STATS_EN
  always_ff @(posedge clk or negedge pc_reset) begin
    if (!pc_reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (push && fetch_count != 16'hFFFF)
        fetch_count <= fetch_count + 16'd1;
      if (byte_ready && !byte_valid && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule
